// File: rtl/io_serial_tx_pkg.sv
// Shared definitions for the serial transmitter: word width, line levels, FSM states.
// Latency: none (definitions only); backpressure: not applicable.
package io_serial_tx_pkg;

    localparam int DATA_BITS = 16;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/io_serial_tx_baud.sv
// Baud timer: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last cycle of each bit.
// Latency: tick is combinational from the count register; backpressure: none.
module io_baud_counter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_tick,
    output logic o_pre_tick
);
    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] PRE  = 8'(CLKS_PER_BIT - 2);

    logic [7:0] r_cnt;
    logic       w_last;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
        end
    end

    assign o_bit_tick = i_enable && w_last;
    // One cycle early, so the owner can register a pulse aligned with the final bit cycle.
    assign o_pre_tick = i_enable && (r_cnt == PRE);

endmodule

// File: rtl/io_serial_tx.sv
// Serial transmitter: 16-bit word sent as start, LSB-first data, optional even parity, stop.
// Latency: start bit on the line one cycle after acceptance; backpressure: tx_ready low while the holding register is full.
module io_serial_tx
    import io_serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic                 IO_TX_clock,
    input  logic                 IO_TX_reset,
    input  logic [DATA_BITS-1:0] tx_data_in,
    input  logic                 tx_data_valid,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_t            r_state;
    tx_state_t            w_state_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] r_hold;
    logic [DATA_BITS-1:0] w_hold_nxt;
    logic                 r_hold_empty;
    logic                 w_hold_empty_nxt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [IDX_W-1:0]     w_bit_idx_nxt;
    logic                 r_parity;
    logic                 w_parity_nxt;
    logic                 r_serial;
    logic                 w_serial_nxt;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_tick;
    logic                 w_pre_tick;
    logic                 w_baud_clear;
    logic                 w_baud_en;

    assign w_accept     = tx_data_valid && r_hold_empty;
    assign w_baud_clear = (r_state == ST_IDLE);
    assign w_baud_en    = (r_state != ST_IDLE);

    io_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk      (IO_TX_clock),
        .i_rst_n    (IO_TX_reset),
        .i_clear    (w_baud_clear),
        .i_enable   (w_baud_en),
        .o_bit_tick (w_tick),
        .o_pre_tick (w_pre_tick)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_hold_nxt       = r_hold;
        w_hold_empty_nxt = r_hold_empty;
        w_bit_idx_nxt    = r_bit_idx;
        w_parity_nxt     = r_parity;

        // While a frame is in flight, a new word parks in the holding register.
        if (w_accept && (r_state != ST_IDLE)) begin
            w_hold_nxt       = tx_data_in;
            w_hold_empty_nxt = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_shift_nxt   = tx_data_in;
                    w_parity_nxt  = even_parity(tx_data_in);
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = ST_START;
                end else if (!r_hold_empty) begin
                    w_shift_nxt      = r_hold;
                    w_parity_nxt     = even_parity(r_hold);
                    w_hold_empty_nxt = 1'b1;
                    w_bit_idx_nxt    = '0;
                    w_state_nxt      = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == LAST_IDX) begin
                        w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                        w_shift_nxt   = r_shift >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (!r_hold_empty) begin
                        // Drain: the parked word goes out next; a word accepted on
                        // this same edge stays parked behind it.
                        w_shift_nxt      = r_hold;
                        w_parity_nxt     = even_parity(r_hold);
                        w_hold_empty_nxt = !w_accept;
                        w_bit_idx_nxt    = '0;
                        w_state_nxt      = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Line level follows the state being entered, so serial_out comes straight from a flop.
    always_comb begin
        w_serial_nxt = LINE_IDLE;
        case (w_state_nxt)
            ST_START:  w_serial_nxt = LINE_START;
            ST_DATA:   w_serial_nxt = w_shift_nxt[0];
            ST_PARITY: w_serial_nxt = w_parity_nxt;
            ST_STOP:   w_serial_nxt = LINE_STOP;
            default:   w_serial_nxt = LINE_IDLE;
        endcase
    end

    always_ff @(posedge IO_TX_clock or negedge IO_TX_reset) begin
        if (!IO_TX_reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_empty <= 1'b1;
            r_bit_idx    <= '0;
            r_parity     <= 1'b0;
            r_serial     <= LINE_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_empty <= w_hold_empty_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_parity     <= w_parity_nxt;
            r_serial     <= w_serial_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_done       <= (r_state == ST_STOP) && w_pre_tick;
        end
    end

    assign tx_ready   = r_hold_empty;
    assign serial_out = r_serial;
    assign tx_busy    = r_busy;
    assign tx_done    = r_done;

endmodule

// File: tb/tb_io_serial_tx.sv
// Bench for io_serial_tx: table of framed words, corner sequences, random traffic vs a timeline model.
module tb_io_serial_tx;
    localparam int CLKS   = 4;
    localparam int PAR    = 1;
    localparam int FRAME  = (18 + PAR) * CLKS;
    localparam int CLKS2  = 2;
    localparam int FRAME2 = 18 * CLKS2;

    typedef struct {
        logic [15:0] w;
        logic        par;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data  = '0;
    logic        valid = 1'b0;
    logic        tx_ready, serial_out, tx_busy, tx_done;
    logic [15:0] d2    = '0;
    logic        v2    = 1'b0;
    logic        r2, s2, b2, dn2;

    always #5 clk = ~clk;

    io_serial_tx #(.CLKS_PER_BIT(CLKS), .PARITY_EN(PAR)) dut (
        .IO_TX_clock(clk), .IO_TX_reset(rst_n), .tx_data_in(data), .tx_data_valid(valid),
        .tx_ready(tx_ready), .serial_out(serial_out), .tx_busy(tx_busy), .tx_done(tx_done));

    io_serial_tx #(.CLKS_PER_BIT(CLKS2), .PARITY_EN(0)) dut2 (
        .IO_TX_clock(clk), .IO_TX_reset(rst_n), .tx_data_in(d2), .tx_data_valid(v2),
        .tx_ready(r2), .serial_out(s2), .tx_busy(b2), .tx_done(dn2));

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int done_at;
    logic line_s [0:511];

    // Model: position m_t (0..FRAME-1) within the current frame, -1 when idle, plus a one-deep queue.
    int          m_t    = -1;
    logic [15:0] m_word = '0;
    logic [15:0] m_hold [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = -1;
            m_hold.delete();
        end else begin
            logic acc;
            acc = valid && (m_hold.size() == 0);
            if (m_t < 0) begin
                if (acc) begin
                    m_word = data;
                    m_t    = 0;
                    acc    = 1'b0;
                end else if (m_hold.size() != 0) begin
                    m_word = m_hold.pop_front();
                    m_t    = 0;
                end
            end else if (m_t == FRAME - 1) begin
                if (m_hold.size() != 0) begin
                    m_word = m_hold.pop_front();
                    m_t    = 0;
                end else begin
                    m_t = -1;
                end
            end else begin
                m_t++;
            end
            if (acc) m_hold.push_back(data);
        end
    end

    function automatic logic line_bit(input logic [15:0] w, input int t);
        int p;
        p = t / CLKS;
        if (p == 0) return 1'b0;
        if (p <= 16) return w[p-1];
        if (PAR != 0 && p == 17) return ^w;
        return 1'b1;
    endfunction

    function automatic logic [3:0] exp_vec();
        logic s, b, d, r;
        s = (m_t < 0) ? 1'b1 : line_bit(m_word, m_t);
        b = (m_t >= 0);
        d = (m_t == FRAME - 1);
        r = (m_hold.size() == 0);
        return {s, b, d, r};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc_n, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        chk("line/busy/done/ready", int'({serial_out, tx_busy, tx_done, tx_ready}), int'(exp_vec()));
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 600 && !(m_t < 0 && m_hold.size() == 0); k++) cyc();
        if (!(m_t < 0 && m_hold.size() == 0)) chk("idle_timeout", 0, 1);
    endtask

    task automatic frame_capture(input logic [15:0] w, input int n);
        valid   = 1'b1;
        data    = w;
        done_at = -1;
        for (int k = 1; k <= n; k++) begin
            cyc();
            if (k == 1) valid = 1'b0;
            line_s[k] = serial_out;
            if (tx_done && done_at < 0) done_at = k;
        end
    endtask

    function automatic logic [15:0] decode(input int s, input int cpb);
        logic [15:0] w;
        for (int b = 0; b < 16; b++) w[b] = line_s[s + cpb * (b + 1) + 1];
        return w;
    endfunction

    initial begin
        vec_t        tbl [6];
        logic [15:0] wq [3];
        int          done1, done2, extra, busy_cnt, ndone, idx;

        tbl[0] = '{16'hA5C3, 1'b0};
        tbl[1] = '{16'h0001, 1'b1};
        tbl[2] = '{16'hFFFF, 1'b0};
        tbl[3] = '{16'h8000, 1'b1};
        tbl[4] = '{16'h1234, 1'b1};
        tbl[5] = '{16'h0000, 1'b0};
        wq[0] = 16'h0F0F;
        wq[1] = 16'hC0DE;
        wq[2] = 16'hBEEF;

        repeat (3) cyc();
        chk("reset_serial", serial_out, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_done", tx_done, 0);
        chk("reset_ready", tx_ready, 1);
        chk("reset_ready_dut2", r2, 1);
        chk("reset_serial_dut2", s2, 1);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 6; i++) begin
            wait_idle();
            frame_capture(tbl[i].w, FRAME + 2);
            chk("start_bit", line_s[1], 0);
            chk("data_word", decode(1, CLKS), tbl[i].w);
            chk("parity_bit", line_s[1 + CLKS * 17 + 1], tbl[i].par);
            chk("stop_bit", line_s[FRAME], 1);
            chk("done_cycle", done_at, FRAME);
            chk("idle_after", line_s[FRAME + 1], 1);
        end

        // Back-to-back pair, with a third word offered while the holding register is full.
        wait_idle();
        valid = 1'b1;
        data  = 16'h0001;
        done1 = -1; done2 = -1; extra = 0; busy_cnt = 0;
        for (int k = 1; k <= 2 * FRAME + 60; k++) begin
            cyc();
            if (k == 1) data = 16'hFFFF;
            if (k == 2) begin
                chk("ready_low_when_held", tx_ready, 0);
                data = 16'h1234;
            end
            if (k == 20) valid = 1'b0;
            line_s[k] = serial_out;
            if (tx_done) begin
                if (done1 < 0) done1 = k;
                else if (done2 < 0) done2 = k;
                else extra++;
            end
            if (k > 2 * FRAME) busy_cnt += int'(tx_busy);
        end
        chk("pair_done1", done1, FRAME);
        chk("pair_done_spacing", done2 - done1, FRAME);
        chk("pair_extra_done", extra, 0);
        chk("pair_word1", decode(1, CLKS), 16'h0001);
        chk("pair_word2", decode(FRAME + 1, CLKS), 16'hFFFF);
        chk("pair_no_gap", line_s[FRAME + 1], 0);
        chk("ignored_word_no_frame", busy_cnt, 0);

        // Reset in the middle of data bit 7, with a word parked in the holding register.
        wait_idle();
        valid = 1'b1;
        data  = 16'h00FF;
        for (int k = 1; k <= 34; k++) begin
            cyc();
            if (k == 1) data = 16'h5555;
            if (k == 2) valid = 1'b0;
        end
        chk("busy_before_reset", tx_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_serial", serial_out, 1);
        chk("midreset_busy", tx_busy, 0);
        chk("midreset_done", tx_done, 0);
        chk("midreset_ready", tx_ready, 1);
        cyc();
        cyc();
        rst_n = 1'b1;
        frame_capture(16'h8000, FRAME + 20);
        chk("post_reset_start", line_s[1], 0);
        chk("post_reset_word", decode(1, CLKS), 16'h8000);
        chk("post_reset_parity", line_s[1 + CLKS * 17 + 1], 1);
        chk("post_reset_done", done_at, FRAME);
        chk("post_reset_no_hold_frame", line_s[FRAME + 10], 1);

        // No-parity instance at two clocks per bit.
        wait_idle();
        v2 = 1'b1;
        d2 = 16'h7FFF;
        done_at = -1; busy_cnt = 0;
        for (int k = 1; k <= FRAME2 + 10; k++) begin
            cyc();
            if (k == 1) v2 = 1'b0;
            line_s[k] = s2;
            if (dn2 && done_at < 0) done_at = k;
            busy_cnt += int'(b2);
        end
        chk("np_done_cycle", done_at, FRAME2);
        chk("np_busy_len", busy_cnt, FRAME2);
        chk("np_start", line_s[1], 0);
        chk("np_word", decode(1, CLKS2), 16'h7FFF);
        chk("np_stop", line_s[FRAME2], 1);
        chk("np_idle_after", line_s[FRAME2 + 1], 1);

        // Three words offered back to back; the third is taken the cycle tx_ready rises on drain.
        wait_idle();
        idx = 0; ndone = 0;
        valid = 1'b1;
        data  = wq[0];
        for (int k = 1; k <= 3 * FRAME + 20; k++) begin
            logic acc;
            acc = valid && tx_ready;
            cyc();
            if (acc) begin
                idx++;
                if (idx == 3) valid = 1'b0;
                else data = wq[idx];
            end
            line_s[k] = serial_out;
            if (tx_done) ndone++;
            if (k == FRAME + 1) chk("ready_rises_on_drain", tx_ready, 1);
        end
        chk("drain_accepted", idx, 3);
        chk("drain_done_count", ndone, 3);
        chk("drain_word1", decode(1, CLKS), wq[0]);
        chk("drain_word2", decode(FRAME + 1, CLKS), wq[1]);
        chk("drain_word3", decode(2 * FRAME + 1, CLKS), wq[2]);

        wait_idle();
        for (int k = 0; k < 2500; k++) begin
            valid = ($urandom_range(0, 9) < 2);
            data  = 16'($urandom);
            cyc();
        end
        valid = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
